// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment mapping for the seven-segment scanner.
package seg_pkg;

  localparam int unsigned SEG_MAX_DIGITS = 16;

  typedef enum logic [2:0] {
    REG_DATA0  = 3'd0,
    REG_DATA1  = 3'd1,
    REG_EN     = 3'd2,
    REG_DP     = 3'd3,
    REG_BLINK  = 3'd4,
    REG_STATUS = 3'd5
  } seg_reg_e;

  // Active-high pattern, bit 0 = segment a; b and d are lowercase glyphs.
  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder on the slot snapshot path.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex7(nibble);

endmodule

// File: rtl/seg_scanner.sv
// Memory-mapped multiplexed seven-segment controller: register file, digit scan,
// per-slot snapshot with dead time, and hardware blink.
module seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned SCAN_DIV     = 1250,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 128
) (
  input  logic              clock,
  input  logic              clrn,
  input  logic              sel,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic [DIGITS-1:0] an_n,
  output logic [7:0]        seg_n
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [63:0] DATA_MASK = (DIGITS >= SEG_MAX_DIGITS) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                                 : ((64'd1 << (4 * DIGITS)) - 64'd1);

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [FRM_W-1:0]  frame;
  logic              phase;

  logic [63:0]       data_q;
  logic [DIGITS-1:0] en_q;
  logic [DIGITS-1:0] dp_q;
  logic [DIGITS-1:0] blink_q;

  logic [6:0]        snap_pat;
  logic              snap_dp;
  logic              snap_lit;

  logic              cnt_last, idx_last, frame_last, slot_start;
  logic [5:0]        nib_base;
  logic [3:0]        cur_nib;
  logic [6:0]        cur_pat;
  logic              lit_now;
  logic [6:0]        use_pat;
  logic              use_dp, use_lit, drive;
  logic              unused_addr;

  assign unused_addr = ^{addr[31:5], addr[1:0]};

  assign cnt_last   = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_last   = (idx == IDX_W'(DIGITS - 1));
  assign frame_last = (frame == FRM_W'(BLINK_FRAMES - 1));
  assign slot_start = (cnt == '0);

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      cnt   <= '0;
      idx   <= '0;
      frame <= '0;
      phase <= 1'b0;
    end else if (cnt_last) begin
      cnt <= '0;
      if (idx_last) begin
        idx <= '0;
        if (frame_last) begin
          frame <= '0;
          phase <= ~phase;
        end else begin
          frame <= frame + 1'b1;
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      data_q  <= '0;
      en_q    <= '1;
      dp_q    <= '0;
      blink_q <= '0;
    end else if (sel && we) begin
      case (addr[4:2])
        REG_DATA0: data_q[31:0]  <= din & DATA_MASK[31:0];
        REG_DATA1: data_q[63:32] <= din & DATA_MASK[63:32];
        REG_EN:    en_q          <= din[DIGITS-1:0];
        REG_DP:    dp_q          <= din[DIGITS-1:0];
        REG_BLINK: blink_q       <= din[DIGITS-1:0];
        default: ;
      endcase
    end
  end

  assign nib_base = 6'(idx) << 2;
  assign cur_nib  = data_q[nib_base +: 4];
  assign lit_now  = en_q[idx] & ~(blink_q[idx] & phase);

  seg_hex_decode u_hex (
    .nibble (cur_nib),
    .seg    (cur_pat)
  );

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      snap_pat <= '0;
      snap_dp  <= 1'b0;
      snap_lit <= 1'b0;
    end else if (slot_start) begin
      snap_pat <= cur_pat;
      snap_dp  <= dp_q[idx];
      snap_lit <= lit_now;
    end
  end

  // On the snapshot edge itself the fresh values bypass the latch, so a zero
  // dead time still lights the digit from the first cycle of its slot.
  assign use_pat = slot_start ? cur_pat   : snap_pat;
  assign use_dp  = slot_start ? dp_q[idx] : snap_dp;
  assign use_lit = slot_start ? lit_now   : snap_lit;
  assign drive   = (cnt >= CNT_W'(BLANK_CYCLES)) && use_lit;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      an_n  <= '1;
      seg_n <= '1;
    end else begin
      an_n  <= drive ? ~(DIGITS'(1) << idx) : '1;
      seg_n <= drive ? ~{use_dp, use_pat} : '1;
    end
  end

  always_comb begin
    dout = '0;
    if (sel) begin
      case (addr[4:2])
        REG_DATA0:  dout = data_q[31:0];
        REG_DATA1:  dout = data_q[63:32];
        REG_EN:     dout = 32'(en_q);
        REG_DP:     dout = 32'(dp_q);
        REG_BLINK:  dout = 32'(blink_q);
        REG_STATUS: dout = {27'd0, phase, 4'(idx)};
        default:    dout = '0;
      endcase
    end
  end

endmodule

// File: doc/seg_scanner.md
# seg_scanner

Memory-mapped, parametrised multiplexed seven-segment display controller replacing the fixed 8-digit scan in the board top level. The CPU writes digit values, enable, decimal-point and blink masks over the data-memory bus (selected by the Mmu `sel_seg` decode). The block time-multiplexes up to 16 active-low common-anode digits, with a programmable scan rate, anti-ghosting dead time and hardware blink.

## Interface

- `DIGITS`, 8: number of digits, 1..16
- `SCAN_DIV`, 1250: clock cycles per digit slot, at least 2
- `BLANK_CYCLES`, 16: dead-time cycles at the start of each slot, strictly less than `SCAN_DIV`
- `BLINK_FRAMES`, 128: full scan frames per blink half-period, at least 1

- `clock`  in  1  system clock, rising edge
- `clrn`  in  1  asynchronous, active-low reset
- `sel`  in  1  address decode hit for this block
- `we`  in  1  write strobe, qualified by `sel`
- `addr`  in  32  byte address; only `addr[4:2]` decoded
- `din`  in  32  write data
- `dout`  out  32  read data, combinational
- `an_n`  out  `DIGITS`  digit anodes, active-low, one-hot-low or all ones
- `seg_n`  out  8  `{dp,g,f,e,d,c,b,a}`, active-low

## Operation

- Register map (word offsets from `addr[4:2]`):
  - 0: DATA0, nibble k = digit k, for digits 0..7
  - 1: DATA1, nibble k = digit 8+k
  - 2: EN, digit enable mask
  - 3: DP, decimal-point mask
  - 4: BLINK, blink mask
  - 5: STATUS, read-only; `[3:0]` current digit index, `[4]` blink phase
- Register bits above `DIGITS` are not stored and read as 0. Unmapped offsets read 0 and ignore writes.
- Write: when `sel & we` is high at a rising edge, the addressed register is updated. Writes to STATUS are ignored.
- Read: `dout` is the addressed register when `sel` is high, otherwise 0.
- Scan counter `cnt` runs 0..`SCAN_DIV`-1. When it wraps, digit index `idx` advances and wraps from `DIGITS`-1 to 0.
- Each `idx` wrap to 0 ends a frame. After `BLINK_FRAMES` frames, `phase` toggles.
- Digit i is lit when `EN[i] & ~(BLINK[i] & phase)` is true.
- Slot snapshot: at the edge where `cnt`==0, the block latches for digit `idx`:
  - the hex-decoded pattern of its nibble
  - its DP bit
  - its lit flag
- Writes made mid-slot do not change the current slot. They appear at that digit's next slot.
- Outputs are registered:
  - while `cnt` < `BLANK_CYCLES`, or while the latched lit flag is 0: `an_n` is all ones
  - otherwise: `an_n` = ~(1 << `idx`), and `seg_n` = ~{latched dp, latched pattern}
- Hex encoding: 0..F standard, with lowercase b and d.

## Timing

- Reset (async, `clrn` low):
  - counters: `cnt`=0, `idx`=0, `phase`=0, frame counter 0
  - registers: DATA 0, EN all ones, DP 0, BLINK 0
  - outputs: `an_n` all ones, `seg_n` all ones
- After reset release, the first snapshot happens at the first rising edge. No digit is driven during the first `BLANK_CYCLES`+1 cycles.
- Slot length is exactly `SCAN_DIV` cycles. Frame length is `DIGITS`×`SCAN_DIV` cycles.
- Blink half-period is `BLINK_FRAMES`×frame cycles.
- Output register latency: one cycle after `cnt`/`idx` state.
- Write to read-back latency: 1 cycle; the register value is visible on `dout` after the write edge.
- Simultaneous write and snapshot on the same edge: the snapshot uses the pre-write value.
- `clrn` asserted mid-slot: all outputs go dark immediately, without waiting for a clock edge.
- `DIGITS`=1: `idx` stays 0 and one frame is one slot.

## Structure

- Package `seg_pkg` holds:
  - register offset constants
  - the `DIGITS` limit constant
  - function `hex7(nibble) -> [6:0]`, with bit 0 = segment a
- One sub-module, `seg_hex_decode`, which is combinational and wraps `hex7`. It is instantiated once, on the snapshot path.
- All counters are in the top module. Width of `cnt` is $clog2(`SCAN_DIV`); widths of `idx` and the frame counter are sized the same way.

## Test plan

Bench parameters: `DIGITS`=8, `SCAN_DIV`=8, `BLANK_CYCLES`=2, `BLINK_FRAMES`=2.

- **Reset:** hold `clrn` low, then release.
  - Expect `an_n`=8'hFF and `seg_n`=8'hFF for 3 cycles.
  - Then digit 0 drives `seg_n`=8'hC0 (shows "0").
- **Write DATA0 = 32'h76543210:**
  - over the next frame, digit k shows hex k; digit 3 gives `seg_n`=8'hB0
  - each anode is low for exactly 6 of every 8 cycles
- **Write EN = 8'h05, DP = 8'h04:**
  - only `an_n[0]` and `an_n[2]` ever go low
  - digit 2 has `seg_n[7]`=0
- **Write BLINK = 8'h01:**
  - digit 0 is dark for 128 cycles, then lit for 128, alternating
  - STATUS bit 4 toggles every 128 cycles
- **Mid-slot write** to digit 1 at `cnt`=4 while digit 1 is active:
  - the current slot is unchanged
  - the new value appears 64 cycles later
- **Read-back:**
  - read offsets 0..5 with `sel`=1, and offset 6
  - `sel`=0 gives `dout`=0
  - offset 6 reads 0
  - DATA1 reads 0 because `DIGITS`=8
